// File: rtl/dev_bus_pkg.sv
// Shared definitions for the simple device bus: host FSM states, command
// record, bus constants and the GPIO register map used by sequencers.
package dev_bus_pkg;

    // Byte-enable width of the device bus.
    localparam int unsigned BeWidth = 4;

    // Default field widths for the command record.
    localparam int unsigned CmdAddrWidth = 32;
    localparam int unsigned CmdDataWidth = 32;

    // GPIO register offsets.
    localparam logic [CmdAddrWidth-1:0] GpioOutOffset    = 32'h0000_0000;
    localparam logic [CmdAddrWidth-1:0] GpioInOffset     = 32'h0000_0004;
    localparam logic [CmdAddrWidth-1:0] GpioInDbncOffset = 32'h0000_0008;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StRsp
    } dev_bus_host_state_e;

    typedef struct packed {
        logic                    we;
        logic [CmdAddrWidth-1:0] addr;
        logic [BeWidth-1:0]      be;
        logic [CmdDataWidth-1:0] wdata;
    } dev_bus_cmd_t;

endpackage

// File: rtl/dev_bus_host.sv
// Single-outstanding device bus initiator: accepts one command, issues one
// device_req_o pulse, waits for rvalid (or times out) and returns the response.
module dev_bus_host
    import dev_bus_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [BeWidth-1:0]   cmd_be_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,

    output logic                 device_req_o,
    output logic [AddrWidth-1:0] device_addr_o,
    output logic                 device_we_o,
    output logic [BeWidth-1:0]   device_be_o,
    output logic [DataWidth-1:0] device_wdata_o,
    input  logic                 device_rvalid_i,
    input  logic [DataWidth-1:0] device_rdata_i
);

    localparam int unsigned CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    // The count is incremented on every empty WAIT cycle; the timeout fires on the
    // cycle whose incremented value would reach TimeoutCycles-1.
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 2);

    dev_bus_host_state_e  state_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 device_req_q;
    logic [AddrWidth-1:0] device_addr_q;
    logic                 device_we_q;
    logic [BeWidth-1:0]   device_be_q;
    logic [DataWidth-1:0] device_wdata_q;
    logic                 rsp_valid_q;
    logic [DataWidth-1:0] rsp_rdata_q;
    logic                 rsp_err_q;

    // FSM, timeout counter, request fields and response capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            device_req_q   <= 1'b0;
            device_addr_q  <= '0;
            device_we_q    <= 1'b0;
            device_be_q    <= '0;
            device_wdata_q <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        state_q        <= StReq;
                        device_req_q   <= 1'b1;
                        device_addr_q  <= cmd_addr_i;
                        device_we_q    <= cmd_we_i;
                        device_be_q    <= cmd_be_i;
                        device_wdata_q <= cmd_wdata_i;
                    end
                end
                StReq: begin
                    state_q        <= StWait;
                    cnt_q          <= '0;
                    device_req_q   <= 1'b0;
                    device_addr_q  <= '0;
                    device_we_q    <= 1'b0;
                    device_be_q    <= '0;
                    device_wdata_q <= '0;
                end
                StWait: begin
                    // rvalid takes priority over a timeout landing on the same cycle.
                    if (device_rvalid_i) begin
                        state_q     <= StRsp;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= device_rdata_i;
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        state_q     <= StRsp;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRsp: begin
                    if (rsp_ready_i) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Ready is a pure function of state so a command is taken only from IDLE.
    always_comb begin
        cmd_ready_o = (state_q == StIdle);
    end

    assign device_req_o   = device_req_q;
    assign device_addr_o  = device_addr_q;
    assign device_we_o    = device_we_q;
    assign device_be_o    = device_be_q;
    assign device_wdata_o = device_wdata_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_dev_bus_host.sv
// Randomised self-checking bench for dev_bus_host with a transaction-level model.
module tb_dev_bus_host;
    import dev_bus_pkg::*;

    localparam int unsigned T      = 16;
    localparam int unsigned NumRnd = 40;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [3:0]  cmd_be_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        device_req_o;
    logic [31:0] device_addr_o;
    logic        device_we_o;
    logic [3:0]  device_be_o;
    logic [31:0] device_wdata_o;
    logic        device_rvalid_i;
    logic [31:0] device_rdata_i;

    dev_bus_host #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(T)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_we_i       (cmd_we_i),
        .cmd_addr_i     (cmd_addr_i),
        .cmd_be_i       (cmd_be_i),
        .cmd_wdata_i    (cmd_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .device_req_o   (device_req_o),
        .device_addr_o  (device_addr_o),
        .device_we_o    (device_we_o),
        .device_be_o    (device_be_o),
        .device_wdata_o (device_wdata_o),
        .device_rvalid_i(device_rvalid_i),
        .device_rdata_i (device_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural GPIO OUT register seen by the device side of the bench.
    logic [31:0] gpio_out = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_req"},       device_req_o,   0);
        check_eq({tag, "_addr"},      device_addr_o,  0);
        check_eq({tag, "_we"},        device_we_o,    0);
        check_eq({tag, "_be"},        device_be_o,    0);
        check_eq({tag, "_wdata"},     device_wdata_o, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid_o,    0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata_o,    0);
        check_eq({tag, "_rsp_err"},   rsp_err_o,      0);
        check_eq({tag, "_cmd_ready"}, cmd_ready_o,    1);
    endtask

    task automatic drive_cmd(input dev_bus_cmd_t c);
        cmd_valid_i = 1'b1;
        cmd_we_i    = c.we;
        cmd_addr_i  = c.addr;
        cmd_be_i    = c.be;
        cmd_wdata_i = c.wdata;
    endtask

    // One full transaction. delay = WAIT cycles before the device pulses rvalid
    // (0 = the cycle right after the req pulse). The model: a response window of
    // T-1 WAIT cycles; rvalid inside it returns the data, otherwise a timeout error.
    task automatic run_txn(input dev_bus_cmd_t c, input int delay, input logic [31:0] rdata,
                           input int ready_wait, input bit pend, input dev_bus_cmd_t nxt);
        int          exp_k;
        int          got_k;
        logic        exp_err;
        logic [31:0] exp_data;
        exp_err  = (delay >= int'(T) - 1);
        exp_k    = exp_err ? int'(T) - 2 : delay;
        exp_data = exp_err ? 32'h0 : rdata;

        drive_cmd(c);
        check_eq("cmd_ready_idle", cmd_ready_o, 1);
        tick();
        if (pend) drive_cmd(nxt);
        else begin
            cmd_valid_i = 1'b0;
            cmd_wdata_i = $urandom;
        end
        check_eq("req_pulse",     device_req_o,   1);
        check_eq("req_addr",      device_addr_o,  c.addr);
        check_eq("req_we",        device_we_o,    c.we);
        check_eq("req_be",        device_be_o,    c.be);
        check_eq("req_wdata",     device_wdata_o, c.wdata);
        check_eq("req_cmd_ready", cmd_ready_o,    0);
        check_eq("req_rsp_valid", rsp_valid_o,    0);
        if (device_req_o && device_we_o && device_addr_o == GpioOutOffset) begin
            for (int b = 0; b < 4; b++)
                if (device_be_o[b]) gpio_out[8*b +: 8] = device_wdata_o[8*b +: 8];
        end
        tick();
        check_eq("wait_req",   device_req_o,   0);
        check_eq("wait_addr",  device_addr_o,  0);
        check_eq("wait_wdata", device_wdata_o, 0);
        check_eq("wait_be",    device_be_o,    0);
        check_eq("wait_ready", cmd_ready_o,    0);

        got_k = -1;
        for (int k = 0; k < int'(T) + 4; k++) begin
            device_rvalid_i = (k == delay);
            device_rdata_i  = (k == delay) ? rdata : $urandom;
            tick();
            device_rvalid_i = 1'b0;
            if (rsp_valid_o) begin
                got_k = k;
                break;
            end
        end
        check_eq("rsp_latency", 64'(got_k), 64'(exp_k));
        check_eq("rsp_rdata",   rsp_rdata_o, exp_data);
        check_eq("rsp_err",     rsp_err_o,   exp_err);

        // Hold the response under backpressure with spurious rvalid noise.
        for (int j = 0; j < ready_wait; j++) begin
            device_rvalid_i = 1'($urandom_range(0, 1));
            device_rdata_i  = $urandom;
            tick();
            device_rvalid_i = 1'b0;
            check_eq("hold_valid", rsp_valid_o,  1);
            check_eq("hold_rdata", rsp_rdata_o,  exp_data);
            check_eq("hold_err",   rsp_err_o,    exp_err);
            check_eq("hold_ready", cmd_ready_o,  0);
            check_eq("hold_req",   device_req_o, 0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check_eq("post_rsp_valid", rsp_valid_o,  0);
        check_eq("post_cmd_ready", cmd_ready_o,  1);
        check_eq("post_req",       device_req_o, 0);
    endtask

    dev_bus_cmd_t cmds[NumRnd+1];
    int           delays[NumRnd];
    int           waits[NumRnd];
    bit           pends[NumRnd];

    initial begin
        dev_bus_cmd_t c0;
        dev_bus_cmd_t c1;
        rst_ni          = 1'b0;
        cmd_valid_i     = 1'b0;
        cmd_we_i        = 1'b0;
        cmd_addr_i      = '0;
        cmd_be_i        = '0;
        cmd_wdata_i     = '0;
        rsp_ready_i     = 1'b0;
        device_rvalid_i = 1'b0;
        device_rdata_i  = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        check_reset_state("reset");
        tick();
        check_reset_state("reset_idle");

        // Spurious rvalid in IDLE has no effect.
        device_rvalid_i = 1'b1;
        device_rdata_i  = 32'hDEAD_BEEF;
        tick();
        device_rvalid_i = 1'b0;
        check_reset_state("idle_spurious");

        // GPIO write then read-back of OUT.
        c0 = '{we: 1'b1, addr: GpioOutOffset, be: 4'b0011, wdata: 32'h0000_A5C3};
        run_txn(c0, 0, $urandom, 0, 1'b0, c0);
        c0 = '{we: 1'b0, addr: GpioOutOffset, be: 4'b1111, wdata: 32'h0};
        run_txn(c0, 0, gpio_out, 0, 1'b0, c0);
        check_eq("gpio_readback", rsp_rdata_o, 32'h0000_A5C3);

        // Read of IN returning 0x5A.
        c0 = '{we: 1'b0, addr: GpioInOffset, be: 4'b1111, wdata: 32'h0};
        run_txn(c0, 0, 32'h0000_005A, 2, 1'b0, c0);

        // Timeout, then rvalid coincident with the final timeout cycle, be=0.
        c0 = '{we: 1'b0, addr: GpioInDbncOffset, be: 4'b0000, wdata: 32'h0};
        run_txn(c0, 100, 32'h1234_5678, 1, 1'b0, c0);
        run_txn(c0, int'(T) - 2, 32'h1234_5678, 1, 1'b0, c0);
        run_txn(c0, int'(T) - 1, 32'h1234_5678, 0, 1'b0, c0);

        // Backpressure for 10 cycles with a second command pending.
        c0 = '{we: 1'b1, addr: 32'h0000_0010, be: 4'b1010, wdata: 32'hCAFE_0001};
        c1 = '{we: 1'b0, addr: 32'h0000_0014, be: 4'b0101, wdata: 32'h0BAD_0002};
        run_txn(c0, 1, 32'h7777_0000, 10, 1'b1, c1);
        run_txn(c1, 0, 32'h8888_0000, 0, 1'b0, c1);

        // Reset mid-WAIT discards the outstanding command.
        drive_cmd(c0);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check_reset_state("mid_wait_reset");
        for (int i = 0; i < int'(T) + 4; i++) begin
            device_rvalid_i = 1'($urandom_range(0, 1));
            device_rdata_i  = $urandom;
            tick();
            device_rvalid_i = 1'b0;
            check_eq("aborted_no_rsp", rsp_valid_o, 0);
        end

        // Randomised traffic.
        for (int i = 0; i <= int'(NumRnd); i++) begin
            cmds[i].we    = 1'($urandom_range(0, 1));
            cmds[i].addr  = $urandom;
            cmds[i].be    = 4'($urandom_range(0, 15));
            cmds[i].wdata = $urandom;
        end
        for (int i = 0; i < int'(NumRnd); i++) begin
            delays[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T + 2))
                                                    : int'($urandom_range(0, 2));
            waits[i]  = int'($urandom_range(0, 4));
            pends[i]  = ($urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < int'(NumRnd); i++) begin
            run_txn(cmds[i], delays[i], $urandom, waits[i], pends[i], cmds[i+1]);
        end
        cmd_valid_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
